// File: rtl/p2_seq.sv
// Run-and-check sequencer for the multicycle MIPS core: reset, run, count steps, then scan GPRs against an expected ROM.
// Optional P2SEQ_MASK_EN adds exp_mask to exclude individual registers from the compare.
module p2_seq #(
    parameter int DATA_W       = 32,
    parameter int REG_CNT      = 32,
    parameter int MAX_STEPS    = 100,
    parameter int RESET_CYCLES = 2,
    parameter int STEP_TIMEOUT = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           instr_done,
    input  logic                           halt,
    output logic                           cpu_rst,
    output logic                           cpu_en,
    output logic [$clog2(REG_CNT)-1:0]     reg_raddr,
    input  logic [DATA_W-1:0]              reg_rdata,
    input  logic [DATA_W-1:0]              exp_rdata,
`ifdef P2SEQ_MASK_EN
    input  logic                           exp_mask,
`endif
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic                           limit,
    output logic [$clog2(MAX_STEPS+1)-1:0] step_cnt,
    output logic [$clog2(REG_CNT+1)-1:0]   err_cnt,
    output logic [$clog2(REG_CNT)-1:0]     first_err
);

    localparam int AW = $clog2(REG_CNT);
    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int EW = $clog2(REG_CNT + 1);
    localparam int WW = $clog2(STEP_TIMEOUT + 1);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_CHECK, S_DONE} state_t;

    state_t        state;
    logic [RW-1:0] rst_cyc;
    logic [WW-1:0] wd;
    logic [EW-1:0] chk;

    logic [SW-1:0] step_nx;
    logic [WW-1:0] wd_nx;
    logic          wd_fire;
    logic          cmp_vld;
    logic          mismatch;
    logic [EW-1:0] err_nx;

    function automatic logic [SW-1:0] step_inc(input logic [SW-1:0] v, input logic en);
        return (en && v < SW'(MAX_STEPS)) ? v + SW'(1) : v;
    endfunction

    function automatic logic [WW-1:0] wd_inc(input logic [WW-1:0] v);
        return (v < WW'(STEP_TIMEOUT)) ? v + WW'(1) : v;
    endfunction

    function automatic logic [EW-1:0] err_inc(input logic [EW-1:0] v, input logic en);
        return (en && v < EW'(REG_CNT)) ? v + EW'(1) : v;
    endfunction

    // chk counts CHECK cycles; a nonzero chk means data for address chk-1 is on the read ports
    always_comb begin
        step_nx = step_inc(step_cnt, instr_done);
        wd_nx   = instr_done ? '0 : wd_inc(wd);
        wd_fire = (wd_nx == WW'(STEP_TIMEOUT));
        cmp_vld = (chk != '0);
`ifdef P2SEQ_MASK_EN
        mismatch = cmp_vld && exp_mask && (reg_rdata !== exp_rdata);
`else
        mismatch = cmp_vld && (reg_rdata !== exp_rdata);
`endif
        err_nx = err_inc(err_cnt, mismatch);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            rst_cyc   <= '0;
            wd        <= '0;
            chk       <= '0;
            cpu_rst   <= 1'b1;
            cpu_en    <= 1'b0;
            reg_raddr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            limit     <= 1'b0;
            step_cnt  <= '0;
            err_cnt   <= '0;
            first_err <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_IDLE)
                        cpu_rst <= 1'b0;
                    if (start) begin
                        state     <= S_RESET;
                        rst_cyc   <= '0;
                        wd        <= '0;
                        chk       <= '0;
                        cpu_rst   <= 1'b1;
                        reg_raddr <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                        limit     <= 1'b0;
                        step_cnt  <= '0;
                        err_cnt   <= '0;
                        first_err <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cyc == RW'(RESET_CYCLES - 1)) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                        cpu_en  <= 1'b1;
                        wd      <= '0;
                    end else begin
                        rst_cyc <= rst_cyc + RW'(1);
                    end
                end
                S_RUN: begin
                    step_cnt <= step_nx;
                    wd       <= wd_nx;
                    // halt wins over limit and watchdog; its own step is still counted
                    if (halt || step_nx == SW'(MAX_STEPS) || wd_fire) begin
                        state     <= S_CHECK;
                        cpu_en    <= 1'b0;
                        chk       <= '0;
                        reg_raddr <= '0;
                        if (!halt && step_nx == SW'(MAX_STEPS))
                            limit <= 1'b1;
                        else if (!halt)
                            timeout <= 1'b1;
                    end
                end
                S_CHECK: begin
                    err_cnt <= err_nx;
                    if (mismatch && err_cnt == '0)
                        first_err <= AW'(chk - EW'(1));
                    if (chk == EW'(REG_CNT)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nx == '0) && !timeout;
                    end else begin
                        chk <= chk + EW'(1);
                        if (int'(chk) + 1 < REG_CNT)
                            reg_raddr <= AW'(chk + EW'(1));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p2_seq.sv
// Bench for p2_seq: a GPR/ROM memory model plus randomized instruction streams checked against rule-level expectations.
module tb_p2_seq;
    localparam int REG_CNT      = 32;
    localparam int MAX_STEPS    = 100;
    localparam int RESET_CYCLES = 2;
    localparam int STEP_TIMEOUT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        instr_done = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_rst, cpu_en, busy, done, pass, timeout, limit;
    logic [4:0]  reg_raddr, first_err;
    logic [31:0] reg_rdata = '0;
    logic [31:0] exp_rdata = '0;
    logic [6:0]  step_cnt;
    logic [5:0]  err_cnt;
`ifdef P2SEQ_MASK_EN
    logic        exp_mask = 1'b1;
    logic        mask [REG_CNT];
`endif

    logic [31:0] gpr [REG_CNT];
    logic [31:0] rom [REG_CNT];

    int n_checks = 0;
    int n_fail   = 0;
    int en_k, rst_cnt, lat, en_low;
    bit busy_ok, clr_ok;

    p2_seq #(
        .DATA_W(32), .REG_CNT(REG_CNT), .MAX_STEPS(MAX_STEPS),
        .RESET_CYCLES(RESET_CYCLES), .STEP_TIMEOUT(STEP_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .instr_done(instr_done), .halt(halt),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .reg_raddr(reg_raddr),
        .reg_rdata(reg_rdata), .exp_rdata(exp_rdata),
`ifdef P2SEQ_MASK_EN
        .exp_mask(exp_mask),
`endif
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .limit(limit),
        .step_cnt(step_cnt), .err_cnt(err_cnt), .first_err(first_err)
    );

    always #5 clk = ~clk;

    // GPR debug port and expected ROM: one-cycle read latency
    always @(posedge clk) begin
        reg_rdata <= gpr[reg_raddr];
        exp_rdata <= rom[reg_raddr];
`ifdef P2SEQ_MASK_EN
        exp_mask  <= mask[reg_raddr];
`endif
    end

    function automatic void model_regs(output int err, output int first);
        err = 0;
        first = 0;
        for (int i = 0; i < REG_CNT; i++) begin
            bit cmp;
            cmp = 1'b1;
`ifdef P2SEQ_MASK_EN
            cmp = mask[i];
`endif
            if (cmp && gpr[i] !== rom[i]) begin
                if (err == 0) first = i;
                err++;
            end
        end
    endfunction

    task automatic fill_regs(input bit corrupt);
        for (int i = 0; i < REG_CNT; i++) begin
            gpr[i] = $urandom;
            rom[i] = gpr[i];
`ifdef P2SEQ_MASK_EN
            mask[i] = 1'b1;
`endif
            if (corrupt && $urandom_range(0, 3) == 0)
                rom[i] = gpr[i] ^ (32'h1 << $urandom_range(0, 31));
        end
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        clr_ok  = (step_cnt == 0 && err_cnt == 0 && first_err == 0 && !timeout && !limit && !pass && !done);
        busy_ok = 1'b1;
        rst_cnt = 0;
        en_k    = 0;
        while (!cpu_en && en_k < 20) begin
            en_k++;
            if (cpu_rst) rst_cnt++;
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
        end
        en_k++;
    endtask

    task automatic run_core(input int n, input int gmin, input int gmax,
                            input bit halt_end, input bit halt_same, input bit poke_start);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmin, gmax)) @(negedge clk);
            instr_done = 1'b1;
            if (i == n - 1) begin
                if (halt_end && halt_same) halt = 1'b1;
                else if (halt_end) begin
                    @(negedge clk); instr_done = 1'b0; halt = 1'b1;
                end
            end else begin
                if (poke_start && i == 0) start = 1'b1;
                @(negedge clk); instr_done = 1'b0; start = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        en_low = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin instr_done = 1'b0; halt = 1'b0; end
            if (!cpu_en && en_low == 0) en_low = k;
        end while (!done && k < 400);
        lat = k;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
        n_checks++; if ({cpu_en, busy, done, pass, timeout, limit} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {cpu_en, busy, done, pass, timeout, limit}); end
        n_checks++; if ({step_cnt, err_cnt, first_err, reg_raddr} !== 23'b0) begin
            n_fail++; $display("FAIL reset_counts: got step=%0d err=%0d first=%0d raddr=%0d expected all 0", step_cnt, err_cnt, first_err, reg_raddr); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL idle_cpu_rst: got %b expected 0", cpu_rst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        fill_regs(1'b0);
        do_start();
        n_checks++; if (en_k != RESET_CYCLES + 1) begin n_fail++; $display("FAIL start_en_latency: got %0d expected %0d", en_k, RESET_CYCLES + 1); end
        n_checks++; if (rst_cnt != RESET_CYCLES) begin n_fail++; $display("FAIL start_rst_cycles: got %0d expected %0d", rst_cnt, RESET_CYCLES); end
        n_checks++; if (!busy_ok || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL start_busy_rst: got busy_ok=%b cpu_rst=%b expected 1 0", busy_ok, cpu_rst); end
        run_core(5, 3, 3, 1'b1, 1'b0, 1'b0);
        wait_done();
        n_checks++; if (en_low != 1) begin n_fail++; $display("FAIL basic_en_off: got %0d expected 1", en_low); end
        n_checks++; if (lat != REG_CNT + 2) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected %0d", lat, REG_CNT + 2); end
        n_checks++; if ({step_cnt, err_cnt, first_err, timeout, limit, pass} !== {7'(5), 6'(0), 5'(0), 3'b001}) begin
            n_fail++; $display("FAIL basic_result: got step=%0d err=%0d first=%0d to=%b lim=%b pass=%b expected step=5 err=0 first=0 to=0 lim=0 pass=1",
                               step_cnt, err_cnt, first_err, timeout, limit, pass); end
        n_checks++; if ({busy, cpu_en} !== 2'b00) begin n_fail++; $display("FAIL basic_idle_flags: got %b expected 00", {busy, cpu_en}); end
    endtask

    task automatic test_mismatch();
        int ee, ef;
        fill_regs(1'b0);
        gpr[3] = 32'h1234_5678; rom[3] = 32'h5;
        gpr[9] = 32'h0000_abcd; rom[9] = 32'h1;
        model_regs(ee, ef);
        do_start();
        run_core(5, 3, 3, 1'b1, 1'b0, 1'b0);
        wait_done();
        n_checks++; if ({step_cnt, err_cnt, first_err, timeout, limit, pass} !== {7'(5), 6'(ee), 5'(ef), 3'b000} || ee != 2) begin
            n_fail++; $display("FAIL mismatch_result: got step=%0d err=%0d first=%0d to=%b lim=%b pass=%b expected step=5 err=2 first=3 pass=0",
                               step_cnt, err_cnt, first_err, timeout, limit, pass); end
    endtask

    task automatic test_timeout();
        fill_regs(1'b0);
        do_start();
        n_checks++; if (!clr_ok) begin n_fail++; $display("FAIL restart_clear: got err=%0d first=%0d done=%b expected cleared", err_cnt, first_err, done); end
        run_core(7, 0, 4, 1'b0, 1'b0, 1'b0);
        wait_done();
        n_checks++; if (en_low != STEP_TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_when: got %0d expected %0d", en_low, STEP_TIMEOUT + 1); end
        n_checks++; if (lat != STEP_TIMEOUT + REG_CNT + 2) begin n_fail++; $display("FAIL timeout_done_latency: got %0d expected %0d", lat, STEP_TIMEOUT + REG_CNT + 2); end
        n_checks++; if ({step_cnt, err_cnt, first_err, timeout, limit, pass} !== {7'(7), 6'(0), 5'(0), 3'b100}) begin
            n_fail++; $display("FAIL timeout_result: got step=%0d err=%0d first=%0d to=%b lim=%b pass=%b expected step=7 err=0 first=0 to=1 lim=0 pass=0",
                               step_cnt, err_cnt, first_err, timeout, limit, pass); end
    endtask

    task automatic test_limit();
        fill_regs(1'b0);
        do_start();
        run_core(MAX_STEPS, 0, 2, 1'b0, 1'b0, 1'b0);
        wait_done();
        n_checks++; if (en_low != 1 || lat != REG_CNT + 2) begin n_fail++; $display("FAIL limit_timing: got en_off=%0d done=%0d expected 1 %0d", en_low, lat, REG_CNT + 2); end
        n_checks++; if ({step_cnt, err_cnt, first_err, timeout, limit, pass} !== {7'(MAX_STEPS), 6'(0), 5'(0), 3'b011}) begin
            n_fail++; $display("FAIL limit_result: got step=%0d err=%0d first=%0d to=%b lim=%b pass=%b expected step=%0d to=0 lim=1 pass=1",
                               step_cnt, err_cnt, first_err, timeout, limit, pass, MAX_STEPS); end
        do_start();
        run_core(MAX_STEPS, 0, 2, 1'b1, 1'b1, 1'b0);
        wait_done();
        n_checks++; if (en_low != 1) begin n_fail++; $display("FAIL halt_limit_en_off: got %0d expected 1", en_low); end
        n_checks++; if ({step_cnt, err_cnt, first_err, timeout, limit, pass} !== {7'(MAX_STEPS), 6'(0), 5'(0), 3'b001}) begin
            n_fail++; $display("FAIL halt_limit_result: got step=%0d err=%0d first=%0d to=%b lim=%b pass=%b expected step=%0d to=0 lim=0 pass=1",
                               step_cnt, err_cnt, first_err, timeout, limit, pass, MAX_STEPS); end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 4; it++) begin
            int n, ee, ef;
            n = $urandom_range(2, 30);
            fill_regs(1'b1);
            model_regs(ee, ef);
            do_start();
            n_checks++; if (en_k != RESET_CYCLES + 1) begin n_fail++; $display("FAIL b2b_en_latency[%0d]: got %0d expected %0d", it, en_k, RESET_CYCLES + 1); end
            run_core(n, 0, 4, 1'b1, 1'b0, 1'b1);
            wait_done();
            n_checks++; if (lat != REG_CNT + 2) begin n_fail++; $display("FAIL b2b_done_latency[%0d]: got %0d expected %0d", it, lat, REG_CNT + 2); end
            n_checks++; if ({step_cnt, err_cnt, first_err, timeout, limit, pass} !== {7'(n), 6'(ee), 5'(ef), 2'b00, ee == 0}) begin
                n_fail++; $display("FAIL b2b_result[%0d]: got step=%0d err=%0d first=%0d to=%b lim=%b pass=%b expected step=%0d err=%0d first=%0d pass=%b",
                                   it, step_cnt, err_cnt, first_err, timeout, limit, pass, n, ee, ef, ee == 0); end
        end
    endtask

    task automatic test_rst_mid();
        int k;
        fill_regs(1'b0);
        do_start();
        run_core(3, 0, 2, 1'b1, 1'b0, 1'b0);
        @(negedge clk); instr_done = 1'b0; halt = 1'b0;
        k = 0;
        while (reg_raddr != 5'd12 && k < 100) begin @(negedge clk); k++; end
        n_checks++; if (k >= 100 || {busy, cpu_en} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_reach: got k=%0d busy=%b en=%b expected CHECK at raddr 12", k, busy, cpu_en); end
        rst = 1'b0;
        #1;
        n_checks++; if (cpu_rst !== 1'b1 || {cpu_en, busy, done, pass, timeout, limit} !== 6'b0) begin
            n_fail++; $display("FAIL rst_mid_flags: got cpu_rst=%b flags=%b expected 1 000000", cpu_rst, {cpu_en, busy, done, pass, timeout, limit}); end
        n_checks++; if ({step_cnt, err_cnt, first_err, reg_raddr} !== 23'b0) begin
            n_fail++; $display("FAIL rst_mid_counts: got step=%0d err=%0d first=%0d raddr=%0d expected all 0", step_cnt, err_cnt, first_err, reg_raddr); end
        @(negedge clk); rst = 1'b1;
        do_start();
        run_core(4, 0, 3, 1'b1, 1'b0, 1'b0);
        wait_done();
        n_checks++; if ({step_cnt, err_cnt, timeout, limit, pass} !== {7'(4), 6'(0), 3'b001}) begin
            n_fail++; $display("FAIL rst_mid_rerun: got step=%0d err=%0d to=%b lim=%b pass=%b expected step=4 err=0 pass=1", step_cnt, err_cnt, timeout, limit, pass); end
    endtask

    task automatic test_mask();
        int ee;
        fill_regs(1'b0);
        rom[0] = gpr[0] ^ 32'h80;
`ifdef P2SEQ_MASK_EN
        mask[0] = 1'b0;
        ee = 0;
`else
        ee = 1;
`endif
        do_start();
        run_core(2, 0, 3, 1'b1, 1'b0, 1'b0);
        wait_done();
        n_checks++; if ({err_cnt, first_err, pass} !== {6'(ee), 5'(0), ee == 0}) begin
            n_fail++; $display("FAIL mask_result: got err=%0d first=%0d pass=%b expected err=%0d first=0 pass=%b", err_cnt, first_err, pass, ee, ee == 0); end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_timeout();
        test_limit();
        test_back_to_back();
        test_rst_mid();
        test_mask();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
